sprite_draw_scheduler: RTL and testbench

//  Shares the single car/sprite painter FSM + X/Y datapath among N_SPR sprite requesters.

---
 rtl/sprite_draw_scheduler_pkg.sv | 24 ++
 rtl/sprite_draw_scheduler_prio_enc_low.sv | 25 ++
 rtl/sprite_draw_scheduler.sv | 120 ++++++++++++
 tb/tb_sprite_draw_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_draw_scheduler_pkg.sv
// rtl/sprite_draw_scheduler_pkg.sv - shared state encodings and width helper
package sprite_draw_scheduler_pkg;

  // Scheduler FSM states, 3-bit encoding
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    WAIT  = 3'd4,
    FIN   = 3'd5
  } state_t;

  // Ceiling log2, used for index and timer widths
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/sprite_draw_scheduler_prio_enc_low.sv
// rtl/sprite_draw_scheduler_prio_enc_low.sv - lowest-set-bit priority encoder
module prio_enc_low
  import sprite_draw_scheduler_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  iReq,
  output logic [IW-1:0] oIdx,
  output logic          oValid
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    oIdx   = '0;
    oValid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (iReq[i]) begin
        oIdx   = IW'(i);
        oValid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// rtl/sprite_draw_scheduler.sv - per-frame sharing of one sprite painter among N_SPR requesters
module sprite_draw_scheduler
  import sprite_draw_scheduler_pkg::*;
#(
  parameter int N_SPR   = 4,
  parameter int XW      = 10,
  parameter int YW      = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic                      iClk,
  input  logic                      iReset,
  input  logic                      iFrameStart,
  input  logic [N_SPR-1:0]          iReq,
  input  logic [N_SPR*XW-1:0]       iPosX,
  input  logic [N_SPR*YW-1:0]       iPosY,
  input  logic                      iPainterDone,
  input  logic                      iClearFlags,
  output logic                      oPainterStart,
  output logic                      oPainterAbort,
  output logic [XW-1:0]             oPosX,
  output logic [YW-1:0]             oPosY,
  output logic [N_SPR-1:0]          oGrant,
  output logic [clog2(N_SPR)-1:0]   oSel,
  output logic                      oBusy,
  output logic                      oFrameDone,
  output logic                      oOverrun,
  output logic                      oTimeout
);

  localparam int SW = clog2(N_SPR);
  localparam int TW = clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t           state;
  state_t           nextState;
  logic [N_SPR-1:0] pending;
  logic [TW-1:0]    timer;
  logic [SW-1:0]    encIdx;
  logic             encValid;
  logic             timerExpired;
  logic             spriteFinished;

  prio_enc_low #(.N(N_SPR), .IW(SW)) uPrioEnc (
    .iReq   (pending),
    .oIdx   (encIdx),
    .oValid (encValid)
  );

  // Watchdog fires on the last allowed WAIT cycle; a done in that same cycle wins
  assign timerExpired   = (state == WAIT) && (timer == TIMER_LAST) && !iPainterDone;
  assign spriteFinished = (state == WAIT) && (iPainterDone || (timer == TIMER_LAST));

  assign oPainterStart = (state == START);
  assign oPainterAbort = timerExpired;
  assign oFrameDone    = (state == FIN);
  assign oBusy         = (state != IDLE);

  // State register
  always_ff @(posedge iClk) begin
    if (iReset) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state decode
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (iFrameStart) nextState = SCAN;
      SCAN:    nextState = encValid ? LOAD : FIN;
      LOAD:    nextState = START;
      START:   nextState = WAIT;
      WAIT:    if (spriteFinished) nextState = SCAN;
      FIN:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Pending snapshot, selection, coordinate/grant registers and watchdog timer
  always_ff @(posedge iClk) begin
    if (iReset) begin
      pending <= '0;
      timer   <= '0;
      oSel    <= '0;
      oPosX   <= '0;
      oPosY   <= '0;
      oGrant  <= '0;
    end else begin
      case (state)
        IDLE:  if (iFrameStart) pending <= iReq;
        SCAN:  if (encValid) oSel <= encIdx;
        LOAD: begin
          oPosX  <= iPosX[int'(oSel)*XW +: XW];
          oPosY  <= iPosY[int'(oSel)*YW +: YW];
          oGrant <= N_SPR'(1) << oSel;
        end
        START: timer <= '0;
        WAIT: begin
          if (spriteFinished) pending[oSel] <= 1'b0;
          else                timer <= timer + 1'b1;
        end
        FIN:   oGrant <= '0;
        default: ;
      endcase
    end
  end

  // Sticky status flags; a same-cycle set beats the clear
  always_ff @(posedge iClk) begin
    if (iReset) begin
      oOverrun <= 1'b0;
      oTimeout <= 1'b0;
    end else begin
      if (iFrameStart && (state != IDLE)) oOverrun <= 1'b1;
      else if (iClearFlags)               oOverrun <= 1'b0;
      if (timerExpired)                   oTimeout <= 1'b1;
      else if (iClearFlags)               oTimeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// tb/tb_sprite_draw_scheduler.sv - scoreboard bench for sprite_draw_scheduler
module tb_sprite_draw_scheduler;

  localparam int N_SPR   = 4;
  localparam int XW      = 10;
  localparam int YW      = 10;
  localparam int TIMEOUT = 8;

  typedef struct {
    int            sel;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } exp_t;

  logic                iClk = 1'b0;
  logic                iReset = 1'b1;
  logic                iFrameStart = 1'b0;
  logic [N_SPR-1:0]    iReq = '0;
  logic [N_SPR*XW-1:0] iPosX = '0;
  logic [N_SPR*YW-1:0] iPosY = '0;
  logic                iPainterDone = 1'b0;
  logic                iClearFlags = 1'b0;
  logic                oPainterStart;
  logic                oPainterAbort;
  logic [XW-1:0]       oPosX;
  logic [YW-1:0]       oPosY;
  logic [N_SPR-1:0]    oGrant;
  logic [1:0]          oSel;
  logic                oBusy;
  logic                oFrameDone;
  logic                oOverrun;
  logic                oTimeout;

  sprite_draw_scheduler #(.N_SPR(N_SPR), .XW(XW), .YW(YW), .TIMEOUT(TIMEOUT)) dut (
    .iClk(iClk), .iReset(iReset), .iFrameStart(iFrameStart), .iReq(iReq),
    .iPosX(iPosX), .iPosY(iPosY), .iPainterDone(iPainterDone), .iClearFlags(iClearFlags),
    .oPainterStart(oPainterStart), .oPainterAbort(oPainterAbort), .oPosX(oPosX), .oPosY(oPosY),
    .oGrant(oGrant), .oSel(oSel), .oBusy(oBusy), .oFrameDone(oFrameDone),
    .oOverrun(oOverrun), .oTimeout(oTimeout)
  );

  always #5 iClk = ~iClk;

  int   cyc = 0;
  int   cyc0 = 0;
  int   checks = 0;
  int   errors = 0;
  int   doneDelay = 0;
  int   doneCnt = 0;
  int   startCount = 0;
  int   abortCount = 0;
  int   abortRel = -1;
  int   doneCount = 0;
  int   doneRel = -1;
  int   startRel[$];
  exp_t sb[$];
  exp_t got;

  always @(posedge iClk) cyc <= cyc + 1;

  // Painter model: pulses done doneDelay cycles after each start (0 = never)
  initial forever begin
    @(negedge iClk);
    iPainterDone = 1'b0;
    if (doneCnt > 0) begin
      doneCnt--;
      if (doneCnt == 0) iPainterDone = 1'b1;
    end
    if (oPainterStart && doneDelay > 0) doneCnt = doneDelay;
    if (iReset) doneCnt = 0;
  end

  // Output monitor: scoreboard check on every painter start, event timestamps
  initial forever begin
    @(negedge iClk);
    if (!iReset) begin
      if (oPainterStart) begin
        startCount++;
        startRel.push_back(cyc - cyc0);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_start: got sel=%0d, required no start", oSel);
        end else begin
          got = sb.pop_front();
          if (oSel !== 2'(got.sel) || oPosX !== got.x || oPosY !== got.y ||
              oGrant !== (4'b0001 << got.sel)) begin
            errors++;
            $display("FAIL sb_start: got sel=%0d x=%0d y=%0d grant=%b, required sel=%0d x=%0d y=%0d",
                     oSel, oPosX, oPosY, oGrant, got.sel, got.x, got.y);
          end
        end
      end
      if (oPainterAbort) begin
        abortCount++;
        abortRel = cyc - cyc0;
      end
      if (oFrameDone) begin
        doneCount++;
        doneRel = cyc - cyc0;
      end
    end
  end

  task automatic startFrame(input logic [N_SPR-1:0] req);
    exp_t e;
    @(negedge iClk);
    for (int i = 0; i < N_SPR; i++) begin
      iPosX[i*XW +: XW] = XW'($urandom_range(0, 1023));
      iPosY[i*YW +: YW] = YW'($urandom_range(0, 1023));
    end
    iReq = req;
    iFrameStart = 1'b1;
    cyc0 = cyc;
    startCount = 0;
    abortCount = 0;
    abortRel = -1;
    doneCount = 0;
    doneRel = -1;
    startRel.delete();
    for (int i = 0; i < N_SPR; i++) begin
      if (req[i]) begin
        e.sel = i;
        e.x = iPosX[i*XW +: XW];
        e.y = iPosY[i*YW +: YW];
        sb.push_back(e);
      end
    end
    @(negedge iClk);
    iFrameStart = 1'b0;
  endtask

  task automatic waitIdle(input int maxCycles, input string name);
    int n;
    n = 0;
    while (oBusy && n < maxCycles) begin
      @(negedge iClk);
      n++;
    end
    checks++;
    if (oBusy) begin
      errors++;
      $display("FAIL %s_idle: busy=1 after %0d cycles, required 0", name, maxCycles);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge iClk);
    checks++;
    if ({oPainterStart, oPainterAbort, oPosX, oPosY, oGrant, oSel, oBusy, oFrameDone,
         oOverrun, oTimeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: start=%b abort=%b x=%0d y=%0d grant=%b sel=%0d busy=%b done=%b ovr=%b to=%b, required all 0",
               oPainterStart, oPainterAbort, oPosX, oPosY, oGrant, oSel, oBusy, oFrameDone, oOverrun, oTimeout);
    end
    iReset = 1'b0;
  endtask

  task automatic test_multi_sprite;
    doneDelay = 5;
    startFrame(4'b1011);
    iReq = 4'b0100;
    waitIdle(100, "multi");
    checks++;
    if (!(startRel.size() == 3 && startRel[0] == 3 && startRel[1] == 11 && startRel[2] == 19)) begin
      errors++;
      $display("FAIL multi_start_cycles: got %p, required 3 11 19", startRel);
    end
    checks++;
    if (doneCount != 1 || doneRel != 26) begin
      errors++;
      $display("FAIL multi_frame_done: got count=%0d cycle=%0d, required count=1 cycle=26", doneCount, doneRel);
    end
    checks++;
    if (sb.size() != 0 || dut.pending !== 4'b0000 || oGrant !== 4'b0000) begin
      errors++;
      $display("FAIL multi_end_state: got left=%0d pending=%b grant=%b, required 0 0000 0000",
               sb.size(), dut.pending, oGrant);
    end
  endtask

  task automatic test_empty_frame;
    doneDelay = 5;
    startFrame(4'b0000);
    waitIdle(20, "empty");
    checks++;
    if (doneCount != 1 || doneRel != 2 || startCount != 0) begin
      errors++;
      $display("FAIL empty_frame: got done=%0d at %0d starts=%0d, required done=1 at 2 starts=0",
               doneCount, doneRel, startCount);
    end
  endtask

  task automatic test_timeout;
    doneDelay = 0;
    startFrame(4'b0100);
    waitIdle(50, "timeout");
    checks++;
    if (abortCount != 1 || abortRel != 11) begin
      errors++;
      $display("FAIL timeout_abort: got count=%0d cycle=%0d, required count=1 cycle=11", abortCount, abortRel);
    end
    checks++;
    if (oTimeout !== 1'b1 || doneRel != 13 || startCount != 1) begin
      errors++;
      $display("FAIL timeout_flag: got flag=%b done_cycle=%0d starts=%0d, required 1 13 1",
               oTimeout, doneRel, startCount);
    end
  endtask

  task automatic test_overrun;
    int seenStarts;
    doneDelay = 5;
    checks++;
    if (oOverrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_initial: got %b, required 0", oOverrun);
    end
    startFrame(4'b0011);
    repeat (4) @(negedge iClk);
    iFrameStart = 1'b1;
    @(negedge iClk);
    iFrameStart = 1'b0;
    checks++;
    if (oOverrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got %b, required 1", oOverrun);
    end
    waitIdle(100, "overrun");
    checks++;
    if (!(startRel.size() == 2 && startRel[0] == 3 && startRel[1] == 11) || doneCount != 1 || doneRel != 18) begin
      errors++;
      $display("FAIL overrun_sequence: got starts %p done=%0d at %0d, required 3 11 done=1 at 18",
               startRel, doneCount, doneRel);
    end
    seenStarts = startCount;
    repeat (10) @(negedge iClk);
    checks++;
    if (startCount != seenStarts || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL overrun_no_restart: got starts=%0d busy=%b, required starts=%0d busy=0",
               startCount, oBusy, seenStarts);
    end
    iClearFlags = 1'b1;
    @(negedge iClk);
    iClearFlags = 1'b0;
    checks++;
    if (oOverrun !== 1'b0 || oTimeout !== 1'b0) begin
      errors++;
      $display("FAIL clear_flags: got overrun=%b timeout=%b, required 0 0", oOverrun, oTimeout);
    end
  endtask

  task automatic test_done_on_timeout;
    doneDelay = 8;
    startFrame(4'b0001);
    waitIdle(50, "done_tie");
    checks++;
    if (abortCount != 0 || oTimeout !== 1'b0 || doneRel != 13 || startCount != 1) begin
      errors++;
      $display("FAIL done_tie: got aborts=%0d timeout=%b done_cycle=%0d starts=%0d, required 0 0 13 1",
               abortCount, oTimeout, doneRel, startCount);
    end
  endtask

  task automatic test_reset_mid_draw;
    doneDelay = 0;
    startFrame(4'b0011);
    repeat (5) @(negedge iClk);
    checks++;
    if (oBusy !== 1'b1 || oGrant !== 4'b0001) begin
      errors++;
      $display("FAIL midreset_precondition: got busy=%b grant=%b, required 1 0001", oBusy, oGrant);
    end
    iReset = 1'b1;
    @(negedge iClk);
    checks++;
    if ({oPainterStart, oPainterAbort, oPosX, oPosY, oGrant, oSel, oBusy, oFrameDone,
         oOverrun, oTimeout} !== '0 || dut.pending !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_outputs: got busy=%b grant=%b sel=%0d x=%0d y=%0d pending=%b, required all 0",
               oBusy, oGrant, oSel, oPosX, oPosY, dut.pending);
    end
    iReset = 1'b0;
    sb.delete();
    doneDelay = 5;
    startFrame(4'b0010);
    waitIdle(50, "postreset");
    checks++;
    if (!(startRel.size() == 1 && startRel[0] == 3) || doneRel != 10 || abortCount != 0 || sb.size() != 0) begin
      errors++;
      $display("FAIL postreset_frame: got starts %p done_cycle=%0d aborts=%0d left=%0d, required 3 10 0 0",
               startRel, doneRel, abortCount, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_multi_sprite();
    test_empty_frame();
    test_timeout();
    test_overrun();
    test_done_on_timeout();
    test_reset_mid_draw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
